// File: rtl/chan_sel_mux.sv
// chan_sel_mux: N-channel, W-bit registered selector with valid/ready flow control.
//
// Picks one producer channel per cycle, either by a host-driven index (mode=0) or by
// round-robin arbitration among requesting channels (mode=1). The chosen word is
// loaded into a single output register that handshakes with one consumer.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    CH*WIDTH flattened channel data, channel k at [k*WIDTH +: WIDTH]
//   in_valid   per-channel request
//   in_ready   per-channel accept (combinational, at most one bit high)
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel index used in fixed-select mode
//   out_data   registered selected word
//   out_chan   registered index of the channel that produced out_data
//   out_valid  output register holds a word
//   out_ready  consumer accept
module chan_sel_mux #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CH    = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CH*WIDTH-1:0]   in_data,
   input  logic [CH-1:0]         in_valid,
   output logic [CH-1:0]         in_ready,
   input  logic                  mode,
   input  logic [$clog2(CH)-1:0] sel,
   output logic [WIDTH-1:0]      out_data,
   output logic [$clog2(CH)-1:0] out_chan,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int unsigned SW = $clog2(CH);

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SW-1:0]    out_chan_q, out_chan_d;
   logic             out_valid_q, out_valid_d;
   logic [SW-1:0]    last_grant_q, last_grant_d;

   logic [SW-1:0]    cand;
   logic             cand_ok;
   logic             free;
   logic             xfer;
   logic [WIDTH-1:0] cand_data;

   assign free = !out_valid_q || out_ready;

   // Candidate selection. Round-robin search starts one past the last grant and wraps
   // through the last grant itself; CH is a power of two so SW-bit addition wraps.
   always_comb begin
      logic [SW-1:0] idx;
      cand    = '0;
      cand_ok = 1'b0;
      idx     = '0;
      if (!mode) begin
         cand    = sel;
         cand_ok = 1'b1;
      end else begin
         for (int unsigned i = 1; i <= CH; i++) begin
            idx = last_grant_q + SW'(i);
            if (!cand_ok && in_valid[idx]) begin
               cand    = idx;
               cand_ok = 1'b1;
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (free && cand_ok) begin
         in_ready[cand] = 1'b1;
      end
   end

   assign xfer = free && cand_ok && in_valid[cand];

   always_comb begin
      cand_data = '0;
      for (int unsigned k = 0; k < CH; k++) begin
         if (cand == SW'(k)) begin
            cand_data = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      out_data_d   = out_data_q;
      out_chan_d   = out_chan_q;
      out_valid_d  = out_valid_q;
      last_grant_d = last_grant_q;
      if (xfer) begin
         out_data_d   = cand_data;
         out_chan_d   = cand;
         out_valid_d  = 1'b1;
         last_grant_d = cand;
      end else if (free) begin
         // Word consumed (or register empty) and nothing new to load.
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q   <= '0;
         out_chan_q   <= '0;
         out_valid_q  <= 1'b0;
         last_grant_q <= SW'(CH - 1);
      end else begin
         out_data_q   <= out_data_d;
         out_chan_q   <= out_chan_d;
         out_valid_q  <= out_valid_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_chan_sel_mux.sv
// tb_chan_sel_mux: randomized and directed bench for chan_sel_mux against a
// behavioural model of the selector's transfer rules.
module tb_chan_sel_mux;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned CH    = 8;
   localparam int unsigned SW    = $clog2(CH);

   logic                clk = 1'b0;
   logic                rst_n;
   logic [CH*WIDTH-1:0] in_data;
   logic [CH-1:0]       in_valid;
   logic [CH-1:0]       in_ready;
   logic                mode;
   logic [SW-1:0]       sel;
   logic [WIDTH-1:0]    out_data;
   logic [SW-1:0]       out_chan;
   logic                out_valid;
   logic                out_ready;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   bit               m_valid;
   logic [WIDTH-1:0] m_data;
   int               m_chan;
   int               m_last;

   always #5 clk = ~clk;

   chan_sel_mux #(
      .WIDTH(WIDTH),
      .CH   (CH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .mode     (mode),
      .sel      (sel),
      .out_data (out_data),
      .out_chan (out_chan),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int cand_of();
      if (!mode) return int'(sel);
      for (int k = 1; k <= int'(CH); k++) begin
         int c;
         c = (m_last + k) % int'(CH);
         if (in_valid[c]) return c;
      end
      return -1;
   endfunction

   function automatic void model_reset();
      m_valid = 1'b0;
      m_data  = '0;
      m_chan  = 0;
      m_last  = int'(CH) - 1;
   endfunction

   task automatic rand_data();
      for (int k = 0; k < int'(CH); k++) in_data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
   endtask

   // One clock: check in_ready before the edge, advance the model, check outputs after.
   task automatic cycle();
      int            c;
      bit            free;
      logic [CH-1:0] exp_rdy;
      #1;
      free    = !m_valid || out_ready;
      c       = cand_of();
      exp_rdy = '0;
      if (free && c >= 0) exp_rdy[c] = 1'b1;
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      @(posedge clk);
      if (free && c >= 0 && in_valid[c]) begin
         m_valid = 1'b1;
         m_data  = in_data[c*WIDTH +: WIDTH];
         m_chan  = c;
         m_last  = c;
      end else if (free) begin
         m_valid = 1'b0;
      end
      #1;
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("out_data", 64'(out_data), 64'(m_data));
      chk("out_chan", 64'(out_chan), 64'(m_chan));
   endtask

   initial begin
      rst_n     = 1'b0;
      in_data   = '0;
      in_valid  = '0;
      mode      = 1'b0;
      sel       = '0;
      out_ready = 1'b0;
      model_reset();
      #2;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_chan", 64'(out_chan), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Round-robin, all valid: 0,1,...,7,0,1
      mode      = 1'b1;
      in_valid  = '1;
      out_ready = 1'b1;
      for (int i = 0; i < int'(CH) + 2; i++) begin
         rand_data();
         cycle();
         chk("rr_seq", 64'(out_chan), 64'(i % int'(CH)));
      end

      // Fixed select: sel=3
      mode = 1'b0;
      sel  = 3'd3;
      rand_data();
      in_data[3*WIDTH +: WIDTH] = 16'hA5A5;
      #1;
      chk("fix_rdy", 64'(in_ready), 64'h08);
      cycle();
      chk("fix_data", 64'(out_data), 64'hA5A5);
      chk("fix_chan", 64'(out_chan), 64'd3);

      // Make last grant 5, then sparse round-robin on channels 2 and 5
      sel = 3'd5;
      cycle();
      mode     = 1'b1;
      in_valid = 8'b0010_0100;
      cycle();
      chk("sparse0", 64'(out_chan), 64'd2);
      cycle();
      chk("sparse1", 64'(out_chan), 64'd5);
      cycle();
      chk("sparse2", 64'(out_chan), 64'd2);
      in_valid = '0;
      #1;
      chk("idle_rdy", 64'(in_ready), 64'd0);
      cycle();
      chk("idle_valid", 64'(out_valid), 64'd0);

      // Back-pressure: load one word, then stall four cycles
      in_valid = '1;
      rand_data();
      cycle();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rand_data();
         cycle();
         chk("bp_rdy", 64'(in_ready), 64'd0);
      end
      // Mid-stream switch to fixed sel=6 while stalled
      mode = 1'b0;
      sel  = 3'd6;
      cycle();
      out_ready = 1'b1;
      cycle();
      chk("sw_valid", 64'(out_valid), 64'd1);
      chk("sw_chan", 64'(out_chan), 64'd6);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         mode      = 1'($urandom);
         sel       = SW'($urandom);
         in_valid  = CH'($urandom) & CH'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         rand_data();
         cycle();
      end

      // Async reset between edges with a held word
      mode      = 1'b1;
      in_valid  = '1;
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      cycle();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_data", 64'(out_data), 64'd0);
      chk("arst_chan", 64'(out_chan), 64'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      cycle();
      chk("arst_first", 64'(out_chan), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
